mul_result_collector: RTL and testbench

- Sits alongside the pipelined 32x32 Wallace multiplier and consumes its 64-bit product output.
- The multiplier has no stall and no valid signal. This block supplies both:
  - tracks issued operations through a LATENCY-deep valid/tag shadow pipe;
  - captures each product into a show-ahead FIFO;
  - exposes a ready/valid result interface downstream;
  - throttles upstream issue with credit accounting so the FIFO can never overflow.

---
 rtl/mul_result_collector_if.sv | 22 ++
 rtl/mul_result_collector.sv | 91 +++++++++
 tb/tb_mul_result_collector.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_result_collector_if.sv
// Handshake bundle between the multiplier result collector, its issuer and its consumer.
interface mul_result_collector_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_product;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag
    );

    modport slave (
        input  in_valid, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag
    );
endinterface

// File: rtl/mul_result_collector.sv
// Result collector for the stall-free pipelined 32x32 multiplier: valid/tag shadow pipe,
// show-ahead result FIFO and credit-based issue throttling. MUL_OVF_FLAG_EN adds out_ovf.
module mul_result_collector #(
    parameter int unsigned LATENCY = 13,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mul_result_collector_if.slave        bus,
    output logic                         mul_en,
    input  logic [63:0]                  mul_product
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic                         out_ovf
`endif
);
    localparam int unsigned CW = $clog2(DEPTH + LATENCY + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [LATENCY-1:0] sh_valid_q;
    logic [TAG_W-1:0]   sh_tag_q [LATENCY];
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [63:0]        mem_product [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];
    logic               issue, push, pop, head_valid;
    logic [CW:0]        credit_used;

    // Credits cover both stored results and those still inside the multiplier.
    assign credit_used  = {1'b0, count_q} + {1'b0, inflight_q};
    assign bus.in_ready = rst_n & (credit_used < DEPTH_C);
    assign issue        = bus.in_valid & bus.in_ready;
    assign mul_en       = issue;

    assign push       = sh_valid_q[LATENCY-1];
    assign head_valid = (count_q != '0);
    assign pop        = head_valid & bus.out_ready;

    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) sh_tag_q[i] <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            sh_valid_q[0] <= issue;
            sh_tag_q[0]   <= bus.in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                sh_valid_q[i] <= sh_valid_q[i-1];
                sh_tag_q[i]   <= sh_tag_q[i-1];
            end
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            if (pop)  rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
        end
    end

    // Storage is written only on a valid landing, so bubble products never enter the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_product[wptr_q] <= mul_product;
            mem_tag[wptr_q]     <= sh_tag_q[LATENCY-1];
        end
    end

    assign bus.out_valid   = head_valid;
    assign bus.out_product = head_valid ? mem_product[rptr_q] : '0;
    assign bus.out_tag     = head_valid ? mem_tag[rptr_q] : '0;

`ifdef MUL_OVF_FLAG_EN
    logic mem_ovf [DEPTH];

    always_ff @(posedge clk) begin
        if (push) mem_ovf[wptr_q] <= |mul_product[63:32];
    end

    assign out_ovf = head_valid ? mem_ovf[rptr_q] : 1'b0;
`endif
endmodule

// File: tb/tb_mul_result_collector.sv
// Directed bench for mul_result_collector with a behavioural 13-stage multiplier model.
module tb_mul_result_collector;
    localparam int unsigned LAT = 13;
    localparam int unsigned DEP = 4;
    localparam int unsigned TW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mul_en;
    logic [63:0] mul_product;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [63:0] mpipe [LAT];
    int          checks = 0;
    int          failures = 0;
`ifdef MUL_OVF_FLAG_EN
    logic        out_ovf;
`endif

    mul_result_collector_if #(.TAG_W(TW)) bus ();

    mul_result_collector #(
        .LATENCY(LAT),
        .DEPTH  (DEP),
        .TAG_W  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mul_en     (mul_en),
        .mul_product(mul_product)
`ifdef MUL_OVF_FLAG_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: captures at the issue edge, product visible LAT-1 edges later.
    always_ff @(posedge clk) begin
        mpipe[0] <= mul_en ? ({32'b0, op_a} * {32'b0, op_b}) : 64'hdead_beef_0bad_f00d;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_product = mpipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        op_a = a;
        op_b = b;
        bus.in_tag = t;
        bus.in_valid = 1'b1;
        #1;
        chk("issue_mul_en", 64'(mul_en), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        int bad;
        bus.in_valid  = 1'b1;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();

        // Reset state, with in_valid high to show issue is gated off.
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mul_en", 64'(mul_en), 64'd0);
        chk("rst_out_product", bus.out_product, 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
`ifdef MUL_OVF_FLAG_EN
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Single op: 123*89 tag 3.
        bus.out_ready = 1'b1;
        issue_op(32'd123, 32'd89, 4'd3);
        repeat (12) step();
        chk("single_early", 64'(bus.out_valid), 64'd0);
        step();
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_product", bus.out_product, 64'd10947);
        chk("single_tag", 64'(bus.out_tag), 64'd3);
`ifdef MUL_OVF_FLAG_EN
        chk("single_ovf", 64'(out_ovf), 64'd0);
`endif
        step();
        chk("single_popped", 64'(bus.out_valid), 64'd0);

        // Back-to-back issues.
        issue_op(32'hffff_ffff, 32'd100, 4'd5);
        issue_op(32'd124, 32'd10, 4'd6);
        issue_op(32'd7, 32'd0, 4'd7);
        repeat (11) step();
        chk("b2b_p0", bus.out_product, 64'd429496729500);
        chk("b2b_t0", 64'(bus.out_tag), 64'd5);
`ifdef MUL_OVF_FLAG_EN
        chk("b2b_ovf0", 64'(out_ovf), 64'd1);
`endif
        step();
        chk("b2b_p1", bus.out_product, 64'd1240);
        chk("b2b_t1", 64'(bus.out_tag), 64'd6);
        step();
        chk("b2b_v2", 64'(bus.out_valid), 64'd1);
        chk("b2b_p2", bus.out_product, 64'd0);
        chk("b2b_t2", 64'(bus.out_tag), 64'd7);
        step();
        chk("b2b_empty", 64'(bus.out_valid), 64'd0);

        // Back-pressure: in_valid held, only DEP issues accepted.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            op_a = 32'(10 + i);
            op_b = 32'd3;
            bus.in_tag = TW'(i);
            #1;
            if (mul_en) pulses++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_pulses", 64'(pulses), 64'(DEP));
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_full_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_product", bus.out_product, 64'((10 + k) * 3));
            chk("bp_tag", 64'(bus.out_tag), 64'(k));
            step();
            if (k == 0) chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        end
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // DEPTH-1 stored, one landing while the head pops.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue_op(32'(1000 + k), 32'd7, TW'(8 + k));
        repeat (12) step();
        chk("pp_head0", bus.out_product, 64'd7000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("pp_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) step();
        chk("pp_head1", bus.out_product, 64'd7007);
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("pp_product", bus.out_product, 64'((1000 + k) * 7));
            chk("pp_tag", 64'(bus.out_tag), 64'(8 + k));
            step();
        end
        chk("pp_drained", 64'(bus.out_valid), 64'd0);

        // Reset while three ops are in flight.
        issue_op(32'd2, 32'd3, 4'd1);
        issue_op(32'd4, 32'd5, 4'd2);
        issue_op(32'd6, 32'd7, 4'd3);
        repeat (3) step();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_mul_en", 64'(mul_en), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (bus.out_valid) bad++;
        end
        chk("mid_no_ghosts", 64'(bad), 64'd0);
        issue_op(32'd5, 32'd6, 4'd9);
        repeat (12) step();
        chk("post_early", 64'(bus.out_valid), 64'd0);
        step();
        chk("post_valid", 64'(bus.out_valid), 64'd1);
        chk("post_product", bus.out_product, 64'd30);
        chk("post_tag", 64'(bus.out_tag), 64'd9);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid) bad++;
        end
        chk("post_single", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
